// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: handshake and strobe bundle between the major-state
// controller / datapath (master) and the fetch sequencer (slave).
interface fetch_sequencer_if;
  logic       start;
  logic       instIsIND;
  logic       instIsPPIND;
  logic       ram_wait;
  logic       irq;

  logic       ram_oe;
  logic       ram_we;
  logic       pc_ck;
  logic       ir_ck;
  logic       ir2rama;
  logic       ind2inc;
  logic       inc2ramd;
  logic       ind_ck;
  logic       irq_ack;
  logic       busy;
  logic       done;
  logic [3:0] state;

  modport master (
    output start, instIsIND, instIsPPIND, ram_wait, irq,
    input  ram_oe, ram_we, pc_ck, ir_ck, ir2rama, ind2inc, inc2ramd,
           ind_ck, irq_ack, busy, done, state
  );

  modport slave (
    input  start, instIsIND, instIsPPIND, ram_wait, irq,
    output ram_oe, ram_we, pc_ck, ir_ck, ir2rama, ind2inc, inc2ramd,
           ind_ck, irq_ack, busy, done, state
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: self-timed FETCH / AUTOINDEX / INDIRECT memory-cycle
// sequencer. Each cycle is a CK phase (stretched by WAIT_STATES and ram_wait)
// followed by a one-clock STB phase. All strobes are Moore-decoded from state.
//
// Optional build macro FETCH_IRQ_EN: when defined, an irq sampled with start
// turns the fetch into an interrupt fetch (no ram_oe, no pc_ck, irq_ack high,
// decode bits ignored). When undefined, irq is ignored and irq_ack is 0.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for start
// F_CK   | instruction fetch, RAM read in progress
// F_STB  | load IR, bump PC, branch on decode bits
// A1_CK  | autoindex: read pointer location via IR address
// A1_STB | autoindex: capture pointer into IND
// A2_CK  | autoindex: IND+1 drives RAM data for write-back
// A2_STB | autoindex: write incremented pointer
// I_CK   | indirect: read effective address via IR address
// I_STB  | indirect: capture effective address into IND
// DONE   | one-clock completion pulse to execute sequencer
module fetch_sequencer #(
  parameter int WAIT_STATES = 0,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.slave  bus
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_F_CK   = 4'd1,
    ST_F_STB  = 4'd2,
    ST_A1_CK  = 4'd3,
    ST_A1_STB = 4'd4,
    ST_A2_CK  = 4'd5,
    ST_A2_STB = 4'd6,
    ST_I_CK   = 4'd7,
    ST_I_STB  = 4'd8,
    ST_DONE   = 4'd9
  } state_t;

  localparam logic [CNT_W-1:0] LP_WAIT = CNT_W'(WAIT_STATES);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_is_ck;
  logic             w_ck_ready;
  logic             w_irq_fetch;

`ifdef FETCH_IRQ_EN
  logic r_irq;

  // Latch the interrupt request together with an accepted start; drop it at sequence end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else if (r_state == ST_IDLE && bus.start) begin
      r_irq <= bus.irq;
    end else if (r_state == ST_DONE) begin
      r_irq <= 1'b0;
    end
  end

  assign w_irq_fetch = r_irq;
`else
  logic w_irq_unused;

  assign w_irq_unused = bus.irq;
  assign w_irq_fetch  = 1'b0;
`endif

  assign w_is_ck = (r_state == ST_F_CK) || (r_state == ST_A1_CK) ||
                   (r_state == ST_A2_CK) || (r_state == ST_I_CK);

  // A CK phase may end only once its wait count is met and memory is ready
  assign w_ck_ready = (r_cnt == LP_WAIT) && !bus.ram_wait;

  // State and wait-counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state selection
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE:   w_state_nxt = bus.start ? ST_F_CK : ST_IDLE;
      ST_F_CK:   w_state_nxt = w_ck_ready ? ST_F_STB : ST_F_CK;
      ST_F_STB: begin
        if (w_irq_fetch)          w_state_nxt = ST_DONE;
        else if (bus.instIsPPIND) w_state_nxt = ST_A1_CK;
        else if (bus.instIsIND)   w_state_nxt = ST_I_CK;
        else                      w_state_nxt = ST_DONE;
      end
      ST_A1_CK:  w_state_nxt = w_ck_ready ? ST_A1_STB : ST_A1_CK;
      ST_A1_STB: w_state_nxt = ST_A2_CK;
      ST_A2_CK:  w_state_nxt = w_ck_ready ? ST_A2_STB : ST_A2_CK;
      ST_A2_STB: w_state_nxt = ST_I_CK;
      ST_I_CK:   w_state_nxt = w_ck_ready ? ST_I_STB : ST_I_CK;
      ST_I_STB:  w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Wait counter: zero on every CK entry, counts while a CK phase is held.
  // It saturates at WAIT_STATES so a long ram_wait stretch cannot wrap it
  // past the terminal value and add a spurious extra wait period.
  always_comb begin
    w_cnt_nxt = '0;
    if (w_is_ck && (w_state_nxt == r_state)) begin
      w_cnt_nxt = (r_cnt == LP_WAIT) ? r_cnt : r_cnt + 1'b1;
    end
  end

  // Moore output decode
  always_comb begin
    bus.ram_oe   = 1'b0;
    bus.ram_we   = 1'b0;
    bus.pc_ck    = 1'b0;
    bus.ir_ck    = 1'b0;
    bus.ir2rama  = 1'b0;
    bus.ind2inc  = 1'b0;
    bus.inc2ramd = 1'b0;
    bus.ind_ck   = 1'b0;
    bus.irq_ack  = 1'b0;
    bus.done     = 1'b0;
    case (r_state)
      ST_F_CK: begin
        bus.ram_oe  = !w_irq_fetch;
        bus.irq_ack = w_irq_fetch;
      end
      ST_F_STB: begin
        bus.pc_ck   = !w_irq_fetch;
        bus.ir_ck   = 1'b1;
        bus.irq_ack = w_irq_fetch;
      end
      ST_A1_CK: begin
        bus.ir2rama = 1'b1;
        bus.ram_oe  = 1'b1;
        bus.ind2inc = 1'b1;
      end
      ST_A1_STB: bus.ind_ck = 1'b1;
      ST_A2_CK: begin
        bus.ir2rama  = 1'b1;
        bus.ind2inc  = 1'b1;
        bus.inc2ramd = 1'b1;
      end
      ST_A2_STB: bus.ram_we = 1'b1;
      ST_I_CK: begin
        bus.ir2rama = 1'b1;
        bus.ram_oe  = 1'b1;
      end
      ST_I_STB: bus.ind_ck = 1'b1;
      ST_DONE:  bus.done   = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy  = (r_state != ST_IDLE);
  assign bus.state = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: two sequencer instances (WAIT_STATES 0 and 2). A
// phase-list reference model expands each transaction into the expected
// per-clock output trace; a table of directed fetches checks aggregate
// latency and strobe counts, and hand sequences cover ram_wait stretch
// and asynchronous reset mid-sequence.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fetch_sequencer_if bus0 ();
  fetch_sequencer_if bus2 ();

  fetch_sequencer #(.WAIT_STATES(0), .CNT_W(4)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  fetch_sequencer #(.WAIT_STATES(2), .CNT_W(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

`ifdef FETCH_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  int n_pass  = 0;
  int n_total = 0;
  bit rw_pat [128];

  typedef struct {
    int sel;
    bit pp;
    bit ind;
    bit irq;
    int lat;
    int n_ind;
    int n_we;
    int n_oe;
    int n_pc;
    int n_ack;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // {state[3:0], ram_oe, ram_we, pc_ck, ir_ck, ir2rama, ind2inc, inc2ramd, ind_ck, irq_ack, busy, done}
  function automatic logic [14:0] obs(input int sel);
    if (sel == 0)
      return {bus0.state, bus0.ram_oe, bus0.ram_we, bus0.pc_ck, bus0.ir_ck, bus0.ir2rama,
              bus0.ind2inc, bus0.inc2ramd, bus0.ind_ck, bus0.irq_ack, bus0.busy, bus0.done};
    else
      return {bus2.state, bus2.ram_oe, bus2.ram_we, bus2.pc_ck, bus2.ir_ck, bus2.ir2rama,
              bus2.ind2inc, bus2.inc2ramd, bus2.ind_ck, bus2.irq_ack, bus2.busy, bus2.done};
  endfunction

  function automatic logic [14:0] exp_vec(input int st, input bit irqf);
    logic [3:0] s4;
    logic oe, we, pc, ir, ira, i2i, i2d, indck, ack, dn;
    s4 = 4'(st);
    {oe, we, pc, ir, ira, i2i, i2d, indck, ack, dn} = '0;
    case (st)
      1: begin oe = !irqf; ack = irqf; end
      2: begin pc = !irqf; ir = 1'b1; ack = irqf; end
      3: begin ira = 1'b1; oe = 1'b1; i2i = 1'b1; end
      4: indck = 1'b1;
      5: begin ira = 1'b1; i2i = 1'b1; i2d = 1'b1; end
      6: we = 1'b1;
      7: begin ira = 1'b1; oe = 1'b1; end
      8: indck = 1'b1;
      9: dn = 1'b1;
      default: ;
    endcase
    return {s4, oe, we, pc, ir, ira, i2i, i2d, indck, ack, (st != 0), dn};
  endfunction

  function automatic bit rw_at(input int t);
    return (t < 128) ? rw_pat[t] : 1'b0;
  endfunction

  task automatic set_in(input int sel, input bit st, input bit pp, input bit ind,
                        input bit irq, input bit rw);
    if (sel == 0) begin
      bus0.start = st; bus0.instIsPPIND = pp; bus0.instIsIND = ind;
      bus0.irq = irq; bus0.ram_wait = rw;
    end else begin
      bus2.start = st; bus2.instIsPPIND = pp; bus2.instIsIND = ind;
      bus2.irq = irq; bus2.ram_wait = rw;
    end
  endtask

  task automatic set_rw(input int sel, input bit rw);
    if (sel == 0) bus0.ram_wait = rw;
    else          bus2.ram_wait = rw;
  endtask

  // Must be called #1 after a rising edge with the selected DUT in IDLE.
  task automatic run_txn(input int sel, input bit pp, input bit ind, input bit irq,
                         output int lat, output int n_ind, output int n_we,
                         output int n_oe, output int n_pc, output int n_ack);
    logic [14:0] tr[$];
    int          ph[$];
    logic [14:0] v;
    bit          irqf;
    int          t;
    int          guard;
    irqf = IRQ_EN && irq;
    t = 0;
    if (irqf)      ph = '{1};
    else if (pp)   ph = '{1, 3, 5, 7};
    else if (ind)  ph = '{1, 7};
    else           ph = '{1};
    foreach (ph[k]) begin
      int n;
      bit adv;
      n = 0;
      do begin
        tr.push_back(exp_vec(ph[k], irqf));
        adv = (n >= sel) && !rw_at(t);
        t++;
        n++;
      end while (!adv);
      tr.push_back(exp_vec(ph[k] + 1, irqf));
      t++;
    end
    tr.push_back(exp_vec(9, 1'b0));
    tr.push_back(exp_vec(0, 1'b0));

    lat = -1; n_ind = 0; n_we = 0; n_oe = 0; n_pc = 0; n_ack = 0;
    set_in(sel, 1'b1, pp, ind, irq, 1'b0);
    @(posedge clk); #1;
    set_in(sel, 1'b0, pp, ind, irq, 1'b0);
    for (int i = 0; i < tr.size(); i++) begin
      v = obs(sel);
      check($sformatf("cycle s%0d t%0d", sel, i), 32'(v), 32'(tr[i]));
      if (v[0] && lat < 0) lat = i;
      n_ind += int'(v[3]);
      n_we  += int'(v[9]);
      n_oe  += int'(v[10]);
      n_pc  += int'(v[8]);
      n_ack += int'(v[2]);
      set_rw(sel, rw_at(i));
      @(posedge clk); #1;
    end
    set_rw(sel, 1'b0);
    guard = 0;
    while (obs(sel) != 15'd0 && guard < 64) begin
      @(posedge clk); #1;
      guard++;
    end
  endtask

  initial begin
    int lat, n_ind, n_we, n_oe, n_pc, n_ack;
    int guard;

    vecs[0] = '{0, 1'b0, 1'b0, 1'b0,  2, 0, 0, 1, 1, 0};
    vecs[1] = '{2, 1'b0, 1'b1, 1'b0,  8, 1, 0, 6, 1, 0};
    vecs[2] = '{0, 1'b1, 1'b1, 1'b0,  8, 2, 1, 3, 1, 0};
    vecs[3] = '{2, 1'b1, 1'b0, 1'b0, 16, 2, 1, 9, 1, 0};
    vecs[4] = '{0, 1'b0, 1'b1, 1'b0,  4, 1, 0, 2, 1, 0};
    vecs[5] = '{2, 1'b0, 1'b0, 1'b0,  4, 0, 0, 3, 1, 0};
`ifdef FETCH_IRQ_EN
    vecs[6] = '{0, 1'b1, 1'b0, 1'b1,  2, 0, 0, 0, 0, 2};
    vecs[7] = '{2, 1'b0, 1'b1, 1'b1,  4, 0, 0, 0, 0, 4};
`else
    vecs[6] = '{0, 1'b1, 1'b0, 1'b1,  8, 2, 1, 3, 1, 0};
    vecs[7] = '{2, 1'b0, 1'b1, 1'b1,  8, 1, 0, 6, 1, 0};
`endif

    reset = 1'b1;
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_in(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    foreach (rw_pat[i]) rw_pat[i] = 1'b0;
    #12;
    check("reset dut0", 32'(obs(0)), 32'd0);
    check("reset dut2", 32'(obs(2)), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("idle hold dut0", 32'(obs(0)), 32'd0);
    check("idle hold dut2", 32'(obs(2)), 32'd0);

    // Directed table
    foreach (vecs[r]) begin
      run_txn(vecs[r].sel, vecs[r].pp, vecs[r].ind, vecs[r].irq,
              lat, n_ind, n_we, n_oe, n_pc, n_ack);
      check($sformatf("lat row%0d", r),    32'(lat),   32'(vecs[r].lat));
      check($sformatf("ind_ck row%0d", r), 32'(n_ind), 32'(vecs[r].n_ind));
      check($sformatf("ram_we row%0d", r), 32'(n_we),  32'(vecs[r].n_we));
      check($sformatf("ram_oe row%0d", r), 32'(n_oe),  32'(vecs[r].n_oe));
      check($sformatf("pc_ck row%0d", r),  32'(n_pc),  32'(vecs[r].n_pc));
      check($sformatf("irq_ack row%0d", r), 32'(n_ack), 32'(vecs[r].n_ack));
    end

    // ram_wait held high for 5 clocks while in A1_CK (trace cycles 2..6)
    for (int i = 2; i <= 6; i++) rw_pat[i] = 1'b1;
    run_txn(0, 1'b1, 1'b0, 1'b0, lat, n_ind, n_we, n_oe, n_pc, n_ack);
    check("lat ram_wait A1", 32'(lat), 32'd13);
    check("ram_oe ram_wait A1", 32'(n_oe), 32'd8);
    foreach (rw_pat[i]) rw_pat[i] = 1'b0;

    // Asynchronous reset in the middle of A2_CK
    set_in(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    set_in(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (bus2.state != 4'd5 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check("reach A2_CK", 32'(bus2.state), 32'd5);
    #2 reset = 1'b1;
    #1;
    check("async reset dut2", 32'(obs(2)), 32'd0);
    check("async reset dut0", 32'(obs(0)), 32'd0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    run_txn(2, 1'b0, 1'b0, 1'b0, lat, n_ind, n_we, n_oe, n_pc, n_ack);
    check("lat after reset", 32'(lat), 32'd4);

    // Randomized fetches against the phase-list model
    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = ($urandom_range(0, 1) == 0) ? 0 : 2;
      foreach (rw_pat[i]) rw_pat[i] = ($urandom_range(0, 3) == 0);
      run_txn(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), lat, n_ind, n_we, n_oe, n_pc, n_ack);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
